midi_uart_rx: RTL
=================

Name: midi_uart_rx

Overview:
- Serial MIDI receiver: the receiving end of the bit-banged MIDI stream that the AY port A bit 2 produces on the audio path.
- Converts a 31250-baud 8N1 asynchronous line into bytes, with a single-entry holding register and a valid/ack handshake.
- Used for loopback and self-test of the MIDI output, and as the front end for an internal synth or an external MIDI-in connector.
- Runs entirely in the system clock domain; the line input is asynchronous.

Parameters:
- CLKS_PER_BIT, 896, system clocks per bit (28 MHz / 31250); minimum 8.
- SYNC_STAGES, 2, input synchronizer depth; minimum 2.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- midi_in  input  1  asynchronous serial line; idle high.
- rx_data  output  8  last accepted byte.
- rx_valid  output  1  high while rx_data holds an unacknowledged byte.
- rx_ack  input  1  consumer acknowledge; meaningful only while rx_valid=1.
- framing_error  output  1  one-cycle pulse when the stop bit samples 0.
- overrun  output  1  sticky; a byte was dropped because the holding register was full.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (async, reset_n=0):
  - Synchronizer flops = 1; FSM = IDLE; counters = 0.
  - rx_data = 8'h00; rx_valid, framing_error, overrun, busy = 0.
  - Reset mid-frame aborts the frame with no output.
- midi_in passes through SYNC_STAGES flops; all logic uses the synchronized value `s`. Falling edge = previous s=1 and current s=0.
- Bit counter width is $clog2(CLKS_PER_BIT). HALF = CLKS_PER_BIT/2 (integer division).
- FSM states:
  - IDLE: on falling edge of s, load counter and go to START.
  - START: wait HALF clocks, then sample. Sample 0: go to DATA, bit index 0, counter reloaded. Sample 1: false start, back to IDLE with no output.
  - DATA: sample every CLKS_PER_BIT clocks at bit centre. Shift LSB first into the shift register. After bit 7, go to STOP.
  - STOP: sample after CLKS_PER_BIT clocks.
    - Sample 1: the byte is complete; apply the holding rules below; go to IDLE.
    - Sample 0: pulse framing_error for 1 cycle, discard the byte, go to BREAK.
  - BREAK: wait for s=1, then go to IDLE. A held-low line (break) never produces bytes.
- Holding register, evaluated in the cycle a byte completes:
  - rx_valid=0: load rx_data, set rx_valid on the next edge.
  - rx_valid=1 and rx_ack=1 in the same cycle: load the new byte, rx_valid stays 1, no overrun.
  - rx_valid=1 and rx_ack=0: new byte dropped, rx_data unchanged, overrun set.
- rx_ack with no byte completing: clears rx_valid and clears overrun. rx_ack while rx_valid=0 is ignored.
- Latency: rx_valid rises 1 clk after the stop-bit sample point, i.e. SYNC_STAGES + HALF + 9×CLKS_PER_BIT + 1 clocks after the line's falling edge (±1).
- A new start edge in the cycle STOP returns to IDLE is detected by IDLE on the next cycle; back-to-back frames with no gap must be received.
- busy = (state != IDLE).

Optional Feature:
- Macro: MIDI_RX_MAJORITY_EN.
- Defined: each start/data/stop sample is the 2-of-3 majority of s at centre−1, centre and centre+1 clocks. The decision is taken at centre+1, so all sample points and rx_valid shift 1 clk later. Single-cycle glitches at bit centre are rejected.
- Undefined: a single sample at centre.
- Port list is identical in both builds.

Decomposition:
- Shared package midi_pkg:
  - State encoding constants IDLE/START/DATA/STOP/BREAK.
  - MIDI_BAUD = 31250.
  - Default CLKS_PER_BIT for 28 MHz.
- Sub-module midi_rx_sync: parameterised SYNC_STAGES flop chain, async reset to 1. Reusable for other async inputs.

Test Plan (bench uses CLKS_PER_BIT=16):
- Send 8'h90, then 8'h3C with a 1-bit gap, acking each within 5 clk → rx_valid pulses twice; rx_data = 8'h90 then 8'h3C; framing_error=0, overrun=0.
- 4-clk low glitch on idle line → FSM returns to IDLE after START; no rx_valid; busy high for ≈HALF+SYNC clk only.
- Frame 8'hA5 with stop bit forced 0, line held low 40 clk, then frame 8'h5A → one framing_error pulse; no byte for 8'hA5; rx_data = 8'h5A accepted afterwards.
- Three back-to-back frames 8'h01, 8'h02, 8'h03, no ack → rx_data = 8'h01, overrun=1. Then ack → rx_valid=0 and overrun=0.
- Assert rx_ack on exactly the cycle a second byte completes → rx_data updates to the second byte, rx_valid stays 1, overrun stays 0.
- reset_n pulsed low mid-DATA of 8'hFF, then a clean 8'h42 → all outputs 0 during reset; next byte reads 8'h42. With MIDI_RX_MAJORITY_EN: a 1-clk inverted glitch at the centre of bit 3 of 8'h42 still yields 8'h42.

Source files
------------

// File: rtl/midi_pkg.sv
// Shared MIDI receiver definitions: FSM state encoding, baud rate and the
// default bit period for a 28 MHz system clock.
package midi_pkg;

  localparam int MIDI_BAUD            = 31250;
  localparam int SYS_CLK_HZ           = 28_000_000;
  localparam int DEFAULT_CLKS_PER_BIT = SYS_CLK_HZ / MIDI_BAUD;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/midi_rx_sync.sv
// Reset-to-one flop chain for bringing an idle-high asynchronous input into
// the clk domain; reusable for any other async line.
module midi_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], d};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '1;
    else          sync_q <= sync_d;
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/midi_uart_rx.sv
// 8N1 MIDI serial receiver with a single-entry holding register and valid/ack.
// Optional build macro MIDI_RX_MAJORITY_EN: 2-of-3 majority vote around each bit centre.
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       midi_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       framing_error,
  output logic       overrun,
  output logic       busy
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] BIT_LOAD = CW'(CLKS_PER_BIT - 1);
`ifdef MIDI_RX_MAJORITY_EN
  // One extra clock so the vote can see centre+1 before deciding.
  localparam logic [CW-1:0] START_LOAD = CW'(HALF);
`else
  localparam logic [CW-1:0] START_LOAD = CW'(HALF - 1);
`endif

  logic            s;
  logic            s_prev_q;
  logic            sample;
  rx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            overrun_q, overrun_d;
  logic            ferr_q, ferr_d;
  logic            byte_done;
  logic            tick;

  midi_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (midi_in),
    .q       (s)
  );

`ifdef MIDI_RX_MAJORITY_EN
  logic s_prev2_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) s_prev2_q <= 1'b1;
    else          s_prev2_q <= s_prev_q;
  end
  assign sample = maj3(s, s_prev_q, s_prev2_q);
`else
  assign sample = s;
`endif

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_prev_q && !s) begin
          state_d = ST_START;
          cnt_d   = START_LOAD;
        end
      end
      ST_START: begin
        if (!tick) cnt_d = cnt_q - 1'b1;
        else if (!sample) begin
          state_d   = ST_DATA;
          cnt_d     = BIT_LOAD;
          bit_idx_d = 3'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (!tick) cnt_d = cnt_q - 1'b1;
        else begin
          shift_d = {sample, shift_q[7:1]};
          cnt_d   = BIT_LOAD;
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      ST_STOP: begin
        if (!tick) cnt_d = cnt_q - 1'b1;
        else if (sample) begin
          byte_done = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          ferr_d  = 1'b1;
          state_d = ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Holding register: an ack in the completion cycle frees room for the new byte.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    if (byte_done) begin
      if (!rx_valid_q || rx_ack) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_ack && rx_valid_q) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_prev_q   <= 1'b1;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      s_prev_q   <= s;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      ferr_q     <= ferr_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign overrun       = overrun_q;
  assign framing_error = ferr_q;
  assign busy          = (state_q != ST_IDLE);

endmodule
